// File: rtl/rv_pkg.sv
// -----------------------------------------------------------------------------
// rv_pkg -- shared constants and types for the write-back slice.
//   XLEN / REG_AW   : data width and register-address width
//   NOP_INST        : canonical bubble instruction (addi x0,x0,0)
//   RD_MSB / RD_LSB : destination-register field inside an instruction word
//   mem_wb_t        : MEM/WB pipeline register payload
//   MEM_WB_BUBBLE   : payload loaded on reset and on flush
//   inst_rd()       : extracts rd from an instruction word
// -----------------------------------------------------------------------------
package rv_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 1 << REG_AW;

  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  localparam int RD_MSB = 11;
  localparam int RD_LSB = 7;

  typedef struct packed {
    logic            valid;
    logic            regwen;
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] inst;
  } mem_wb_t;

  localparam mem_wb_t MEM_WB_BUBBLE = '{valid: 1'b0, regwen: 1'b0,
                                        data: '0, inst: NOP_INST};

  function automatic logic [REG_AW-1:0] inst_rd(input logic [XLEN-1:0] inst);
    return inst[RD_MSB:RD_LSB];
  endfunction
endpackage

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file -- 32x32 register file, two combinational read ports, one
// synchronous write port, x0 hardwired to zero.
//   clk, rst             : clock, synchronous active-high reset (clears all)
//   i_we/i_waddr/i_wdata : write port, committed on the rising edge
//   i_raddr1/i_raddr2    : read addresses
//   o_rdata1/o_rdata2    : combinational read data
// Build option: WB_BYPASS_EN -- when defined, a read of the address being
// written this cycle returns the write data instead of the stored value.
// -----------------------------------------------------------------------------
module reg_file
  import rv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [REG_AW-1:0] i_raddr1,
  input  logic [REG_AW-1:0] i_raddr2,
  output logic [XLEN-1:0]   o_rdata1,
  output logic [XLEN-1:0]   o_rdata2
);

  logic [XLEN-1:0] r_regs [NREGS];

  // Reset wins over a write presented in the same cycle, so a pending
  // write-back is dropped. Entry 0 is only ever loaded with zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata1 = (i_raddr1 == '0) ? '0 : r_regs[i_raddr1];
`ifdef WB_BYPASS_EN
    if (i_we && (i_waddr != '0) && (i_raddr1 == i_waddr)) o_rdata1 = i_wdata;
`endif
  end

  always_comb begin
    o_rdata2 = (i_raddr2 == '0) ? '0 : r_regs[i_raddr2];
`ifdef WB_BYPASS_EN
    if (i_we && (i_waddr != '0) && (i_raddr2 == i_waddr)) o_rdata2 = i_wdata;
`endif
  end

endmodule

// File: rtl/write_back.sv
// -----------------------------------------------------------------------------
// write_back -- MEM/WB pipeline register, register file and retire counter.
//   clk, rst          : clock, synchronous active-high reset
//   stall             : hold MEM/WB payload, issue no new write
//   flush             : load a bubble into MEM/WB (beats stall)
//   RegWEn/DataD      : write enable and data from the memory-access stage
//   inst_in           : instruction word, rd in [11:7]
//   rs1_addr/rs2_addr : decode-stage read addresses
//   DataA/DataB       : combinational register-file read data
//   wb_we/wb_rd/wb_data : this cycle's write, exported for forwarding
//   retire_cnt        : count of retired valid instructions (wraps)
// Build option: WB_BYPASS_EN (see reg_file).
//
// Qualifier semantics: r_mem_wb.valid marks a payload that is in WB for the
// first time. It is set only by a normal capture edge and cleared by stall,
// flush and reset, so each instruction writes and retires exactly once even
// while its payload is held by a stall.
// -----------------------------------------------------------------------------
module write_back
  import rv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              RegWEn,
  input  logic [XLEN-1:0]   DataD,
  input  logic [XLEN-1:0]   inst_in,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic [XLEN-1:0]   DataA,
  output logic [XLEN-1:0]   DataB,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   retire_cnt
);

  mem_wb_t         r_mem_wb;
  logic [XLEN-1:0] r_retire_cnt;

  logic              w_we;
  logic [REG_AW-1:0] w_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_wb     <= MEM_WB_BUBBLE;
      r_retire_cnt <= '0;
    end else begin
      if (flush) begin
        r_mem_wb <= MEM_WB_BUBBLE;
      end else if (stall) begin
        // Payload held; only the qualifier drops.
        r_mem_wb.valid <= 1'b0;
      end else begin
        r_mem_wb.valid  <= 1'b1;
        r_mem_wb.regwen <= RegWEn;
        r_mem_wb.data   <= DataD;
        r_mem_wb.inst   <= inst_in;
      end
      if (r_mem_wb.valid) r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  assign w_rd = inst_rd(r_mem_wb.inst);
  assign w_we = r_mem_wb.valid & r_mem_wb.regwen & (w_rd != '0);

  assign wb_we      = w_we;
  assign wb_rd      = w_rd;
  assign wb_data    = r_mem_wb.data;
  assign retire_cnt = r_retire_cnt;

  reg_file u_reg_file (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_we),
    .i_waddr  (w_rd),
    .i_wdata  (r_mem_wb.data),
    .i_raddr1 (rs1_addr),
    .i_raddr2 (rs2_addr),
    .o_rdata1 (DataA),
    .o_rdata2 (DataB)
  );

endmodule
